// File: rtl/sync_frame_tx_pkg.sv
// Shared types and defaults for the serial sync-word frame transmitter.
package sync_frame_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_e;

  localparam int                    SYNC_W_DEF    = 6;
  localparam logic [SYNC_W_DEF-1:0] SYNC_WORD_DEF = 6'b110101;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_frame_tx_if.sv
// Payload handshake plus serial line/status bundle of the frame transmitter.
interface sync_frame_tx_if #(parameter int DATA_W = 8);
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              din_ready;
  logic              y;
  logic              busy;
  logic              frame_done;

  modport master (output din_valid, output din,
                  input  din_ready, input y, input busy, input frame_done);
  modport slave  (input  din_valid, input din,
                  output din_ready, output y, output busy, output frame_done);
endinterface

// File: rtl/sync_frame_tx_piso_shift.sv
// Parallel-in serial-out payload register; MSB is presented first.
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              msb_o
);

  logic [DATA_W-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i)          shreg_d = din_i;
    else if (shift_en_i) shreg_d = shreg_q << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) shreg_q <= '0;
    else     shreg_q <= shreg_d;
  end

  assign msb_o = shreg_q[DATA_W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, payload MSB first, optional even parity
// (enabled by defining PARITY_EN), then idle-zero gap. y is registered.
module sync_frame_tx
  import sync_frame_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_W     = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = SYNC_WORD_DEF,
  parameter int                GAP_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  sync_frame_tx_if.slave bus
);

  localparam int CW  = $clog2(max3(SYNC_W, DATA_W, GAP_CYCLES) + 1);
  localparam int SIW = $clog2(SYNC_W);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            y_q, y_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            din_ready, accept, shift_en, msb;
  logic [SIW-1:0]  sync_idx;

  assign din_ready = (state_q == IDLE) & ~rst;
  assign accept    = bus.din_valid & din_ready;

  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .shift_en_i (shift_en),
    .din_i      (bus.din),
    .msb_o      (msb)
  );

`ifdef PARITY_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (rst)         par_q <= 1'b0;
    else if (accept) par_q <= ^bus.din;
  end
`endif

  // Next state; the shared counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) state_d = SYNC;
      end
      SYNC: if (cnt_q == SYNC_LAST) begin state_d = DATA; cnt_d = '0; end
      DATA: if (cnt_q == DATA_LAST) begin
`ifdef PARITY_EN
        state_d = PAR;
`else
        state_d = GAP;
`endif
        cnt_d = '0;
      end
      PAR:  begin state_d = GAP; cnt_d = '0; end
      GAP:  if (cnt_q == GAP_LAST) begin state_d = IDLE; cnt_d = '0; end
      default: begin state_d = IDLE; cnt_d = '0; end
    endcase
  end

  // Outputs are computed from the next state so the registered line shows
  // the bit belonging to the state it enters; the PISO shifts one step ahead.
  always_comb begin
    y_d      = 1'b0;
    shift_en = 1'b0;
    sync_idx = SIW'(SYNC_W - 1) - SIW'(cnt_d);
    case (state_d)
      SYNC: y_d = SYNC_WORD[sync_idx];
      DATA: begin y_d = msb; shift_en = 1'b1; end
`ifdef PARITY_EN
      PAR:  y_d = par_q;
`endif
      default: y_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == GAP) && (cnt_d == GAP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.y          = y_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
